// File: rtl/iob_uart_console_bridge.sv
// Bus master bridging the UART native register interface to two byte streams.
// Initialises the UART, then alternately polls RX-ready and TX-ready.
module iob_uart_console_bridge_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);
    logic [7:0]  r_mem [2**AW];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        w_pop;
    logic        w_push;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end
endmodule

module iob_uart_console_bridge #(
    parameter int          ADDR_W       = 5,
    parameter int          DATA_W       = 32,
    parameter logic [15:0] DIV          = 16'd434,
    parameter int          DIV_ADDR     = 0,
    parameter int          TXEN_ADDR    = 4,
    parameter int          RXEN_ADDR    = 5,
    parameter int          TXDATA_ADDR  = 8,
    parameter int          TXREADY_ADDR = 9,
    parameter int          RXDATA_ADDR  = 10,
    parameter int          RXREADY_ADDR = 11,
    parameter int          RXFIFO_AW    = 4,
    parameter int          TXFIFO_AW    = 4,
    parameter int          TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                reset,
    output logic                uart_valid,
    output logic [ADDR_W-1:0]   uart_addr,
    output logic [DATA_W-1:0]   uart_wdata,
    output logic [DATA_W/8-1:0] uart_wstrb,
    input  logic [DATA_W-1:0]   uart_rdata,
    input  logic                uart_ready,
    output logic                rx_valid,
    output logic [7:0]          rx_data,
    input  logic                rx_ready,
    input  logic                tx_valid,
    input  logic [7:0]          tx_data,
    output logic                tx_ready,
    output logic                init_done,
    output logic                err
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [2:0] {
        S_INIT_DIV, S_INIT_TXEN, S_INIT_RXEN,
        S_POLL_RX, S_RD_RX, S_POLL_TX, S_WR_TX
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NB-1:0]       r_wstrb;
    logic [7:0]          r_cnt;
    logic                r_init_done;
    logic                r_err;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [NB-1:0]       w_wstrb;
    logic                w_skip;
    logic                w_issue;
    logic                w_done;
    logic                w_tmo;
    logic [7:0]          w_rbyte;
    logic                w_bit;
    logic                w_rx_push;
    logic                w_rx_empty;
    logic                w_rx_full;
    logic                w_tx_pop;
    logic                w_tx_push;
    logic                w_tx_empty;
    logic                w_tx_full;
    logic [7:0]          w_tx_head;

    function automatic int lane_of(input logic [ADDR_W-1:0] a);
        return int'(a) % NB;
    endfunction

    assign w_done  = r_valid && uart_ready;
    assign w_tmo   = r_valid && !uart_ready && (r_cnt == 8'(TIMEOUT - 1));
    assign w_issue = !r_valid && !w_skip;
    assign w_rbyte = 8'(uart_rdata >> (8 * lane_of(r_addr)));
    assign w_bit   = w_rbyte[0];

    assign w_rx_push = (r_state == S_RD_RX) && w_done;
    assign w_tx_pop  = (r_state == S_WR_TX) && w_done;
    assign w_tx_push = tx_valid && tx_ready;

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        w_skip  = 1'b0;
        unique case (r_state)
            S_INIT_DIV: begin
                w_addr  = ADDR_W'(DIV_ADDR);
                w_wdata = {(DATA_W/16){DIV}};
                w_wstrb = NB'(3) << (DIV_ADDR % NB);
            end
            S_INIT_TXEN: begin
                w_addr  = ADDR_W'(TXEN_ADDR);
                w_wdata = {NB{8'd1}};
                w_wstrb = NB'(1) << (TXEN_ADDR % NB);
            end
            S_INIT_RXEN: begin
                w_addr  = ADDR_W'(RXEN_ADDR);
                w_wdata = {NB{8'd1}};
                w_wstrb = NB'(1) << (RXEN_ADDR % NB);
            end
            S_POLL_RX: begin
                w_addr = ADDR_W'(RXREADY_ADDR);
                w_skip = w_rx_full;
            end
            S_RD_RX: w_addr = ADDR_W'(RXDATA_ADDR);
            S_POLL_TX: begin
                w_addr = ADDR_W'(TXREADY_ADDR);
                w_skip = w_tx_empty;
            end
            S_WR_TX: begin
                w_addr  = ADDR_W'(TXDATA_ADDR);
                w_wdata = {NB{w_tx_head}};
                w_wstrb = NB'(1) << (TXDATA_ADDR % NB);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (w_tmo) begin
            w_next = S_POLL_RX;
        end else begin
            unique case (r_state)
                S_INIT_DIV:  if (w_done) w_next = S_INIT_TXEN;
                S_INIT_TXEN: if (w_done) w_next = S_INIT_RXEN;
                S_INIT_RXEN: if (w_done) w_next = S_POLL_RX;
                S_POLL_RX: begin
                    if (w_skip && !r_valid) w_next = S_POLL_TX;
                    else if (w_done) w_next = w_bit ? S_RD_RX : S_POLL_TX;
                end
                S_RD_RX: if (w_done) w_next = S_POLL_TX;
                S_POLL_TX: begin
                    if (w_skip && !r_valid) w_next = S_POLL_RX;
                    else if (w_done) w_next = w_bit ? S_WR_TX : S_POLL_RX;
                end
                S_WR_TX: if (w_done) w_next = S_POLL_RX;
                default: w_next = S_INIT_DIV;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_INIT_DIV;
        else       r_state <= w_next;
    end

    // Request fields latch on issue and stay put until the handshake ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_cnt   <= '0;
        end else if (w_issue) begin
            r_valid <= 1'b1;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_cnt   <= '0;
        end else if (w_done || w_tmo) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_INIT_RXEN && w_done) r_init_done <= 1'b1;
            if (w_tmo) r_err <= 1'b1;
        end
    end

    iob_uart_console_bridge_fifo #(.AW(RXFIFO_AW)) u_rxfifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_din   (w_rbyte),
        .i_pop   (rx_ready),
        .o_dout  (rx_data),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    iob_uart_console_bridge_fifo #(.AW(TXFIFO_AW)) u_txfifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_tx_push),
        .i_din   (tx_data),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    assign uart_valid = r_valid;
    assign uart_addr  = r_addr;
    assign uart_wdata = r_wdata;
    assign uart_wstrb = r_wstrb;
    assign rx_valid   = !w_rx_empty;
    assign tx_ready   = !w_tx_full && r_init_done;
    assign init_done  = r_init_done;
    assign err        = r_err;
endmodule

// File: doc/iob_uart_console_bridge.md
Name: iob_uart_console_bridge

Overview:
- Synthesizable bus master that drives the UART core's native register interface, replacing CPU-driven polling.
- On reset exit it initialises the UART (divisor, TX enable, RX enable). It then round-robin polls RX-ready and TX-ready.
- Moves bytes between the UART and two host-side byte streams, each buffered by a FIFO.
- Sits between the UART and a console/host agent (debug hub, DMA, or simulation stub).

Parameters:
- ADDR_W, 5, byte address width of UART register space.
- DATA_W, 32, bus data width (multiple of 8).
- DIV, 16'd434, baud divisor written at init.
- DIV_ADDR, 0, address of divisor register.
- TXEN_ADDR, 4, address of TX enable register.
- RXEN_ADDR, 5, address of RX enable register.
- TXDATA_ADDR, 8, address of TX data register.
- TXREADY_ADDR, 9, address of TX ready register.
- RXDATA_ADDR, 10, address of RX data register.
- RXREADY_ADDR, 11, address of RX ready register.
- RXFIFO_AW, 4, log2 depth of RX FIFO (UART to host).
- TXFIFO_AW, 4, log2 depth of TX FIFO (host to UART).
- TIMEOUT, 255, max cycles waiting for uart_ready before abort (8-bit counter).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- uart_valid  out  1  bus request.
- uart_addr  out  ADDR_W  byte address.
- uart_wdata  out  DATA_W  write data.
- uart_wstrb  out  DATA_W/8  byte strobes; 0 means read.
- uart_rdata  in  DATA_W  read data.
- uart_ready  in  1  transaction complete.
- rx_valid  out  1  received byte available to host.
- rx_data  out  8  received byte.
- rx_ready  in  1  host accepts byte.
- tx_valid  in  1  host offers byte.
- tx_data  in  8  byte to transmit.
- tx_ready  out  1  TX FIFO not full.
- init_done  out  1  init sequence finished.
- err  out  1  sticky bus timeout flag.

Behaviour:
- Reset (async):
  - uart_valid=0; uart_addr=0; uart_wdata=0; uart_wstrb=0.
  - rx_valid=0; tx_ready=0; init_done=0; err=0.
  - Both FIFOs emptied; FSM goes to INIT_DIV.
- Bus rules:
  - One outstanding transaction at a time.
  - uart_valid, uart_addr, uart_wdata and uart_wstrb are registered and held stable until the cycle uart_ready=1.
  - uart_valid drops in the cycle after uart_ready. At least one idle cycle separates transactions.
- Byte lanes:
  - Lane = addr mod (DATA_W/8). Write data is replicated onto that lane; wstrb has only that lane bit set.
  - Exception: the DIV write uses the 16-bit lanes at DIV_ADDR with 2 strobe bits.
  - Read data is taken from the lane selected by addr; for READY registers, bit 0 of the lane is used.
- Timeout:
  - Counter resets at each request and increments while valid=1 and ready=0.
  - At TIMEOUT: drop valid, set err (sticky until reset), and go to POLL_RX. Any pending RXDATA or TXDATA is discarded; the TX FIFO is not popped.
- FSM states and transitions:
  - INIT_DIV: write DIV. Next INIT_TXEN.
  - INIT_TXEN: write 1. Next INIT_RXEN.
  - INIT_RXEN: write 1. Next POLL_RX, and init_done=1 from the following cycle.
  - POLL_RX: skip to POLL_TX if the RX FIFO is full (no read issued). Otherwise read RXREADY. If the bit is 1, go to RD_RX; else go to POLL_TX.
  - RD_RX: read RXDATA; push the byte into the RX FIFO on uart_ready. Next POLL_TX.
  - POLL_TX: skip to POLL_RX if the TX FIFO is empty. Otherwise read TXREADY. If the bit is 1, go to WR_TX; else go to POLL_RX.
  - WR_TX: write the TX FIFO head to TXDATA; pop on uart_ready. Next POLL_RX.
  - Strict alternation means at most one byte per direction per round.
- tx_ready:
  - Equals !txfifo_full && init_done.
  - Push when tx_valid && tx_ready.
  - Pop and push in the same cycle are allowed; count is unchanged.
- RX output:
  - First-word-fall-through: rx_valid = !rxfifo_empty; rx_data = head.
  - Pop on rx_valid && rx_ready.
  - Push and pop in the same cycle are allowed, including when full (pop frees a slot, push is accepted).
  - Full-state skip in POLL_RX uses the registered full flag; no byte is ever dropped.
- FIFO pointers: wrap modulo 2^AW, with an extra MSB to distinguish full from empty.
- Reset mid-transaction: uart_valid drops asynchronously and the init sequence restarts.

Test Plan:
- Init: release reset; UART model acks each request after 2 cycles -> exactly three writes in order:
  - addr 0, wstrb 0011, wdata[15:0]=434;
  - addr 4, wstrb 0001, data 1;
  - addr 5, wstrb 0010, data 1;
  - init_done=1 one cycle after third ack.
- RX path: model RXREADY=1 with byte 0x41, then 0x42; rx_ready=1 -> rx_data 0x41 then 0x42, in order. No RXDATA read while RXREADY=0.
- TX path: push 0x48, 0x69 with TXREADY=1 -> two writes to addr 8: wstrb 0001 with wdata[7:0]=0x48, then wstrb 0001 with wdata[7:0]=0x69. Hold TXREADY=0 -> no TXDATA writes and FIFO count stays 2.
- RX full: RXFIFO_AW=2, rx_ready=0, model always has data -> exactly 4 bytes buffered and RXREADY polling stops. Pop one -> exactly one more RXDATA read.
- Timeout: model never asserts ready on TXDATA write -> valid drops after 255 cycles, err=1, TX byte still at FIFO head, polling resumes.
- Async reset during WR_TX with valid high -> uart_valid=0 immediately, FIFOs empty, next request is the DIV write.
